// File: rtl/stat_pkg.sv
// stat_pkg: shared defaults, FSM state encoding and captured-result record for stat_merge_ctrl
package stat_pkg;
  localparam int NUM_LANES_DEF = 5;
  localparam int MERGE_LAT_DEF = 2;
  localparam int CNT_W_DEF     = 32;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, HOLD} state_e;

  typedef struct packed {
    logic [63:0]          sum;
    logic [63:0]          sq;
    logic [CNT_W_DEF-1:0] cycles;
    logic                 err;
  } stat_res_t;
endpackage

// File: rtl/stat_merge_ctrl.sv
// stat_merge_ctrl: sequences one statistics window (clear, accumulate, drain, hold result); ACCUM timeout enabled by STAT_TIMEOUT_EN
module stat_merge_ctrl
  import stat_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int MERGE_LAT = MERGE_LAT_DEF,
  parameter int CNT_W     = CNT_W_DEF
`ifdef STAT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 lane_clear,
  output logic                 lane_en,
  input  logic [NUM_LANES-1:0] lane_done,
  input  logic [63:0]          merged_sum,
  input  logic [63:0]          merged_sq,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_sum,
  output logic [63:0]          res_sq,
  output logic [CNT_W-1:0]     res_cycles,
  output logic                 res_err
);
  localparam int DW = $clog2(MERGE_LAT + 2);

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [DW-1:0]        drn_q, drn_d;
  stat_res_t            res_q, res_d;
  logic                 all_done, tmo_hit, err_now;

  // A window that ends with lanes still missing can only have come from the timeout.
`ifdef STAT_TIMEOUT_EN
  assign tmo_hit = cyc_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign err_now = ~&mask_q;
`else
  assign tmo_hit = 1'b0;
  assign err_now = 1'b0;
`endif

  assign all_done   = &(mask_q | lane_done);
  assign busy       = state_q != IDLE;
  assign lane_clear = state_q == CLEAR;
  assign res_sum    = res_q.sum;
  assign res_sq     = res_q.sq;
  assign res_cycles = CNT_W'(res_q.cycles);
  assign res_err    = res_q.err;

  // Next-state, counters and result capture; abort overrides every state.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cyc_d     = cyc_q;
    drn_d     = drn_q;
    res_d     = res_q;
    lane_en   = 1'b0;
    res_valid = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      res_d.err = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:  state_d = start ? CLEAR : IDLE;
        CLEAR: begin
          mask_d    = '0;
          cyc_d     = '0;
          drn_d     = '0;
          res_d.err = 1'b0;
          state_d   = ACCUM;
        end
        ACCUM: begin
          lane_en = !(all_done || tmo_hit);
          mask_d  = mask_q | lane_done;
          cyc_d   = cyc_q + CNT_W'(~&cyc_q);
          state_d = (all_done || tmo_hit) ? DRAIN : ACCUM;
        end
        DRAIN: begin
          drn_d = drn_q + 1'b1;
          if (drn_q == DW'(MERGE_LAT)) begin
            res_d.sum    = merged_sum;
            res_d.sq     = merged_sq;
            res_d.cycles = CNT_W_DEF'(cyc_q);
            res_d.err    = err_now;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          res_valid = 1'b1;
          if (res_ready) begin
            res_d.err = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cyc_q   <= '0;
      drn_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cyc_q   <= cyc_d;
      drn_q   <= drn_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_stat_merge_ctrl.sv
// tb_stat_merge_ctrl: randomized self-checking bench for stat_merge_ctrl against a window-level reference model
module tb_stat_merge_ctrl;
  import stat_pkg::*;
  localparam int NL  = NUM_LANES_DEF;
  localparam int ML  = MERGE_LAT_DEF;
  localparam int TMO = 16;

  logic          clk = 0, nreset = 0, start = 0, abort = 0, res_ready = 0;
  logic [NL-1:0] lane_done = '0;
  logic [63:0]   merged_sum = '0, merged_sq = '0;
  logic          lane_clear, lane_en, busy, res_valid, res_err;
  logic [63:0]   res_sum, res_sq;
  logic [31:0]   res_cycles;
  int            n_chk = 0, n_fail = 0;
  logic [63:0]   last_sum = '0, last_sq = '0;
  logic [31:0]   last_cyc = '0;

  always #5 clk = ~clk;

  stat_merge_ctrl #(
    .NUM_LANES(NL), .MERGE_LAT(ML), .CNT_W(32)
`ifdef STAT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort),
    .lane_clear(lane_clear), .lane_en(lane_en), .lane_done(lane_done),
    .merged_sum(merged_sum), .merged_sq(merged_sq), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_sq(res_sq), .res_cycles(res_cycles), .res_err(res_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full window: fd[i] is the ACCUM cycle (1-based) of lane i's first done, 0 = never.
  task automatic window(input string nm, input int fd[NL], input int hold_n, input bit spam,
                        input bit rnd, input logic [63:0] sum_c, input logic [63:0] sq_c);
    int d;
    bit tmo;
    logic [63:0] s, q;
    d = 0;
    tmo = 0;
    for (int i = 0; i < NL; i++) begin
      if (fd[i] == 0) tmo = 1;
      if (fd[i] > d) d = fd[i];
    end
`ifdef STAT_TIMEOUT_EN
    if (tmo || d > TMO) begin
      tmo = 1;
      d = TMO;
    end
`endif
    s = sum_c;
    q = sq_c;
    merged_sum = sum_c;
    merged_sq = sq_c;
    res_ready = 0;
    start = 1;
    lane_done = spam ? NL'($urandom) : '0;
    #1;
    n_chk++;
    if ({busy, lane_clear, lane_en, res_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle: got %b want 0000", nm, {busy, lane_clear, lane_en, res_valid});
    end
    step();
    start = spam ? 1'($urandom_range(1)) : 1'b0;
    lane_done = spam ? NL'($urandom) : '0;
    #1;
    n_chk++;
    if ({busy, lane_clear, lane_en, res_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL %s clear: got %b want 1100", nm, {busy, lane_clear, lane_en, res_valid});
    end
    step();
    for (int k = 1; k <= d; k++) begin
      for (int i = 0; i < NL; i++)
        lane_done[i] = (k == fd[i]) || (spam && fd[i] != 0 && k > fd[i] && $urandom_range(1) == 1);
      start = spam ? 1'($urandom_range(1)) : 1'b0;
      if (rnd) begin
        merged_sum = {$urandom, $urandom};
        merged_sq = {$urandom, $urandom};
      end
      #1;
      n_chk++;
      if ({busy, lane_clear, lane_en, res_valid} !== {1'b1, 1'b0, k < d, 1'b0}) begin
        n_fail++;
        $display("FAIL %s accum k=%0d: got %b want %b", nm, k, {busy, lane_clear, lane_en, res_valid},
                 {1'b1, 1'b0, k < d, 1'b0});
      end
      step();
    end
    for (int j = 1; j <= ML + 1; j++) begin
      lane_done = spam ? NL'($urandom) : '0;
      start = spam ? 1'($urandom_range(1)) : 1'b0;
      if (rnd) begin
        merged_sum = {$urandom, $urandom};
        merged_sq = {$urandom, $urandom};
      end
      if (j == ML + 1) begin
        s = merged_sum;
        q = merged_sq;
      end
      #1;
      n_chk++;
      if ({busy, lane_clear, lane_en, res_valid} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s drain j=%0d: got %b want 1000", nm, j, {busy, lane_clear, lane_en, res_valid});
      end
      step();
    end
    for (int h = 0; h <= hold_n; h++) begin
      res_ready = (h == hold_n);
      lane_done = spam ? NL'($urandom) : '0;
      start = spam ? 1'($urandom_range(1)) : 1'b0;
      if (rnd) begin
        merged_sum = {$urandom, $urandom};
        merged_sq = {$urandom, $urandom};
      end
      #1;
      n_chk++;
      if ({busy, lane_clear, lane_en, res_valid, res_sum, res_sq, res_cycles, res_err} !==
          {4'b1001, s, q, 32'(d), tmo}) begin
        n_fail++;
        $display("FAIL %s hold h=%0d: got v=%b sum=%h sq=%h cyc=%0d err=%b want sum=%h sq=%h cyc=%0d err=%b",
                 nm, h, {busy, lane_clear, lane_en, res_valid}, res_sum, res_sq, res_cycles, res_err,
                 s, q, d, tmo);
      end
      step();
    end
    res_ready = 0;
    start = 0;
    lane_done = '0;
    #1;
    n_chk++;
    if ({busy, res_valid, res_err, res_sum, res_sq, res_cycles} !== {3'b000, s, q, 32'(d)}) begin
      n_fail++;
      $display("FAIL %s post: got b/v/e=%b sum=%h sq=%h cyc=%0d want 000 sum=%h sq=%h cyc=%0d", nm,
               {busy, res_valid, res_err}, res_sum, res_sq, res_cycles, s, q, d);
    end
    step();
    last_sum = s;
    last_sq = q;
    last_cyc = 32'(d);
  endtask

  task automatic test_reset();
    start = 1;
    lane_done = '1;
    #3;
    n_chk++;
    if ({busy, lane_clear, lane_en, res_valid, res_err, res_sum, res_sq, res_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs not zero (busy=%b sum=%h)", busy, res_sum);
    end
    @(posedge clk);
    #3;
    start = 0;
    lane_done = '0;
    nreset = 1;
    step();
    n_chk++;
    if ({busy, lane_clear, lane_en, res_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000", {busy, lane_clear, lane_en, res_valid});
    end
  endtask

  task automatic test_basic();
    int fd[NL];
    fd = '{10, 10, 10, 10, 10};
    window("basic", fd, 0, 0, 0, 64'd100, 64'd2000);
  endtask

  task automatic test_staggered();
    int fd[NL];
    fd = '{3, 7, 7, 12, 20};
    window("stagger", fd, 2, 0, 0, 64'h1234_5678_9abc_def0, 64'hffff_0000_ffff_0000);
  endtask

  task automatic test_backpressure();
    int fd[NL];
    for (int i = 0; i < NL; i++) fd[i] = $urandom_range(14, 1);
    window("backpressure", fd, 50, 1, 1, '0, '0);
  endtask

  task automatic test_abort();
    start = 1;
    step();
    start = 0;
    step();
    for (int k = 1; k <= 5; k++) begin
      lane_done = (k == 5) ? '1 : '0;
      abort = (k == 5);
      if (k < 5) begin
        #1;
        n_chk++;
        if ({busy, lane_en, res_valid} !== 3'b110) begin
          n_fail++;
          $display("FAIL abort_accum k=%0d: got %b want 110", k, {busy, lane_en, res_valid});
        end
      end
      step();
    end
    abort = 0;
    for (int k = 0; k < 6; k++) begin
      lane_done = '1;
      #1;
      n_chk++;
      if ({busy, lane_en, res_valid, res_err, res_sum, res_sq, res_cycles} !== {4'b0000, last_sum, last_sq, last_cyc}) begin
        n_fail++;
        $display("FAIL abort_idle k=%0d: got b/e/v/err=%b sum=%h cyc=%0d want 0000 sum=%h cyc=%0d", k,
                 {busy, lane_en, res_valid, res_err}, res_sum, res_cycles, last_sum, last_cyc);
      end
      step();
    end
    lane_done = '0;
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    #1;
    n_chk++;
    if ({busy, lane_clear} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_start: got %b want 00", {busy, lane_clear});
    end
    step();
    begin
      int fd[NL];
      fd = '{1, 2, 3, 4, 5};
      window("after_abort", fd, 1, 0, 1, '0, '0);
    end
  endtask

  task automatic test_async_reset();
    start = 1;
    step();
    start = 0;
    step();
    lane_done = '1;
    step();
    lane_done = '0;
    #1;
    n_chk++;
    if ({busy, lane_en, res_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL areset_drain: got %b want 100", {busy, lane_en, res_valid});
    end
    #1;
    nreset = 0;
    #1;
    n_chk++;
    if ({busy, lane_clear, lane_en, res_valid, res_err, res_sum, res_sq, res_cycles} !== '0) begin
      n_fail++;
      $display("FAIL areset: outputs not zero (busy=%b valid=%b sum=%h)", busy, res_valid, res_sum);
    end
    @(posedge clk);
    #3;
    nreset = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      lane_done = '1;
      #1;
      n_chk++;
      if ({busy, lane_en, res_valid, res_sum} !== '0) begin
        n_fail++;
        $display("FAIL areset_after k=%0d: got busy=%b en=%b valid=%b sum=%h want 0", k, busy, lane_en,
                 res_valid, res_sum);
      end
      step();
    end
    lane_done = '0;
    last_sum = '0;
    last_sq = '0;
    last_cyc = '0;
    begin
      int fd[NL];
      fd = '{6, 2, 9, 4, 1};
      window("after_reset", fd, 0, 1, 0, 64'd7, 64'd49);
    end
  endtask

  task automatic test_timeout();
`ifdef STAT_TIMEOUT_EN
    int fd[NL];
    fd = '{3, 5, 7, 9, 0};
    window("timeout", fd, 3, 0, 1, '0, '0);
`else
    start = 1;
    step();
    start = 0;
    step();
    for (int k = 1; k <= 1000; k++) begin
      lane_done = 5'b01111;
      #1;
      n_chk++;
      if ({busy, lane_en, res_valid} !== 3'b110) begin
        n_fail++;
        $display("FAIL no_timeout k=%0d: got %b want 110", k, {busy, lane_en, res_valid});
      end
      step();
    end
    abort = 1;
    step();
    abort = 0;
    lane_done = '0;
    #1;
    n_chk++;
    if ({busy, res_valid, res_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_timeout_abort: got %b want 000", {busy, res_valid, res_err});
    end
    step();
`endif
  endtask

  task automatic test_random();
    int fd[NL];
    for (int w = 0; w < 15; w++) begin
      for (int i = 0; i < NL; i++) fd[i] = $urandom_range(14, 1);
      window("random", fd, $urandom_range(5), 1, 1, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_staggered();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
